// File: rtl/garage_door_ctrl.sv
// garage_door_ctrl: N_DOORS independent door FSMs with limit, obstruction, stop/reverse and run-timeout fault.
// Defining GARAGE_AUTOCLOSE_EN adds a per-door auto-close timer for doors left open and idle.
module garage_door_ctrl #(
  parameter int N_DOORS     = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int ACLOSE_CYC  = 5000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DOORS-1:0] activate,
  input  logic [N_DOORS-1:0] up_max,
  input  logic [N_DOORS-1:0] dn_max,
  input  logic [N_DOORS-1:0] obstruct,
  output logic [N_DOORS-1:0] up_m,
  output logic [N_DOORS-1:0] dn_m,
  output logic [N_DOORS-1:0] fault,
  output logic               busy
);

  localparam int RUN_W = $clog2(TIMEOUT_CYC);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MV_UP   = 3'd1,
    MV_DN   = 3'd2,
    STOPPED = 3'd3,
    FAULT   = 3'd4
  } state_t;

  if (N_DOORS < 1 || N_DOORS > 8 || TIMEOUT_CYC < 2 || ACLOSE_CYC < 2) begin : g_param_check
    $error("garage_door_ctrl: parameter out of range");
  end

  for (genvar i = 0; i < N_DOORS; i++) begin : g_door
    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             act_prev_q, act_prev_d;
    logic             armed_q, armed_d;
    logic             last_up_q, last_up_d;
    logic             up_m_q, up_m_d;
    logic             dn_m_q, dn_m_d;
    logic             fault_q, fault_d;
    logic             act_edge;
    logic             conflict;
    logic             aclose_hit;

    // armed_q stays low for the first edge after reset so a button already held does not fire
    assign act_edge = armed_q & activate[i] & ~act_prev_q;
    assign conflict = up_max[i] & dn_max[i];

`ifdef GARAGE_AUTOCLOSE_EN
    localparam int IDLE_W = $clog2(ACLOSE_CYC);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(ACLOSE_CYC - 1);
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              idle_open;

    assign idle_open  = (state_q == IDLE) & up_max[i] & ~obstruct[i] & ~act_edge;
    assign aclose_hit = idle_open & (idle_cnt_q == IDLE_LAST);

    always_comb begin
      idle_cnt_d = '0;
      if (idle_open && !aclose_hit) idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) idle_cnt_q <= '0;
      else      idle_cnt_q <= idle_cnt_d;
    end
`else
    assign aclose_hit = 1'b0;
`endif

    always_comb begin
      state_d    = state_q;
      act_prev_d = activate[i];
      armed_d    = 1'b1;
      case (state_q)
        IDLE: begin
          if (conflict) state_d = FAULT;
          else if (act_edge) begin
            if (up_max[i] && !dn_max[i]) begin
              if (!obstruct[i]) state_d = MV_DN;
            end else begin
              state_d = MV_UP;
            end
          end else if (aclose_hit) state_d = MV_DN;
        end
        MV_UP: begin
          if (conflict)                  state_d = FAULT;
          else if (up_max[i])            state_d = IDLE;
          else if (run_cnt_q == RUN_LAST) state_d = FAULT;
          else if (act_edge)             state_d = STOPPED;
        end
        MV_DN: begin
          if (conflict)                  state_d = FAULT;
          else if (dn_max[i])            state_d = IDLE;
          else if (obstruct[i])          state_d = MV_UP;
          else if (run_cnt_q == RUN_LAST) state_d = FAULT;
          else if (act_edge)             state_d = STOPPED;
        end
        STOPPED: begin
          if (conflict) state_d = FAULT;
          else if (act_edge) begin
            if (!last_up_q)        state_d = MV_UP;
            else if (!obstruct[i]) state_d = MV_DN;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase

      up_m_d    = (state_d == MV_UP);
      dn_m_d    = (state_d == MV_DN);
      fault_d   = (state_d == FAULT);
      last_up_d = last_up_q;
      if (up_m_d)      last_up_d = 1'b1;
      else if (dn_m_d) last_up_d = 1'b0;

      // the run counter restarts whenever a new run begins, including an obstruction reversal
      run_cnt_d = '0;
      if ((up_m_d || dn_m_d) && (state_d == state_q)) run_cnt_d = run_cnt_q + RUN_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q    <= IDLE;
        run_cnt_q  <= '0;
        act_prev_q <= 1'b0;
        armed_q    <= 1'b0;
        last_up_q  <= 1'b0;
        up_m_q     <= 1'b0;
        dn_m_q     <= 1'b0;
        fault_q    <= 1'b0;
      end else begin
        state_q    <= state_d;
        run_cnt_q  <= run_cnt_d;
        act_prev_q <= act_prev_d;
        armed_q    <= armed_d;
        last_up_q  <= last_up_d;
        up_m_q     <= up_m_d;
        dn_m_q     <= dn_m_d;
        fault_q    <= fault_d;
      end
    end

    assign up_m[i]  = up_m_q;
    assign dn_m[i]  = dn_m_q;
    assign fault[i] = fault_q;
  end

  assign busy = |(up_m | dn_m);

endmodule

// File: doc/garage_door_ctrl.md
GARAGE_DOOR_CTRL -- requirements
Module: garage_door_ctrl

Interface
REQ-001 Parameter N_DOORS, default 2: number of independent door channels, 1..8.
REQ-002 Parameter TIMEOUT_CYC, default 1000: maximum motor run cycles before fault, at least 2.
REQ-003 Parameter ACLOSE_CYC, default 5000: auto-close delay in cycles, at least 2; used only with GARAGE_AUTOCLOSE_EN.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 activate  input  N_DOORS  per-door push button, level; only rising edges act.
REQ-007 up_max  input  N_DOORS  per-door fully-open limit switch.
REQ-008 dn_max  input  N_DOORS  per-door fully-closed limit switch.
REQ-009 obstruct  input  N_DOORS  per-door beam-break sensor, 1 = obstruction present.
REQ-010 up_m  output  N_DOORS  per-door open-motor drive.
REQ-011 dn_m  output  N_DOORS  per-door close-motor drive.
REQ-012 fault  output  N_DOORS  per-door latched fault flag.
REQ-013 busy  output  1  OR of all up_m and dn_m bits.

Function
REQ-014 Each door channel SHALL have an independent FSM with states IDLE, MV_UP, MV_DN, STOPPED and FAULT; channels SHALL share no state.
- IDLE: no drive.
- MV_UP: up_m=1.
- MV_DN: dn_m=1.
- STOPPED: no drive; last direction held in a 1-bit register.
- FAULT: no drive, fault=1.
REQ-015 Outputs SHALL be Moore-decoded from the state register; up_m and dn_m SHALL never both be 1.
REQ-016 An activate edge SHALL be detected when activate=1 at the current edge and the registered previous sample is 0; a held activate SHALL produce one event only.
REQ-017 The first drive cycle SHALL be the cycle after the clock edge that detects the event.
REQ-018 IDLE transitions on an activate edge:
- dn_max=1 and up_max=0: go to MV_UP.
- up_max=1, dn_max=0 and obstruct=0: go to MV_DN.
- up_max=1, dn_max=0 and obstruct=1: stay in IDLE.
- both limits 0: go to MV_UP.
REQ-019 Per-door transition priority, highest first:
- up_max=1 and dn_max=1 together: go to FAULT.
- Reaching the limit for the current direction: go to IDLE.
- obstruct=1 while in MV_DN: go to MV_UP.
- Timeout: go to FAULT.
- Activate edge while moving: go to STOPPED.
REQ-020 STOPPED SHALL go on an activate edge to the direction opposite to the stored last direction; opening to MV_UP is allowed regardless of obstruct, and closing to MV_DN is blocked while obstruct=1.
REQ-021 Each door SHALL have a run counter.
- It clears on entry to MV_UP or MV_DN, including an obstruction reversal.
- It increments each cycle while the door is moving.
- When the counter equals TIMEOUT_CYC-1 and no limit is reached, the door goes to FAULT at the next edge.
- Counter width SHALL be $clog2(TIMEOUT_CYC) bits.
REQ-022 FAULT SHALL be left only by reset; activate, limits and obstruct SHALL be ignored in FAULT.
REQ-023 Unused state encodings SHALL go to IDLE at the next edge.

Reset
REQ-024 While rst=0, all FSMs SHALL be in IDLE, and all counters, edge-detect registers, last-direction bits, up_m, dn_m, fault and busy SHALL be 0, taking effect immediately without a clock edge.
REQ-025 Reset asserted mid-travel SHALL drop motor drive asynchronously.
REQ-026 After release, an activate level already high SHALL NOT count as an edge.

Configuration
REQ-027 With GARAGE_AUTOCLOSE_EN defined:
- A per-door idle counter increments while the door is in IDLE with up_max=1 and obstruct=0.
- The counter clears on an activate edge, on obstruct=1, or on leaving this condition.
- On reaching ACLOSE_CYC-1, the door goes to MV_DN.
- Counter width SHALL be $clog2(ACLOSE_CYC) bits.
REQ-028 Without GARAGE_AUTOCLOSE_EN, no idle counter logic SHALL be built, ACLOSE_CYC SHALL be unused, and an open door SHALL remain in IDLE indefinitely.

Verification
REQ-029 The bench SHALL run with N_DOORS=2, TIMEOUT_CYC=16 and ACLOSE_CYC=8, and SHALL cover these scenarios:
- Open-close cycle: door0 with dn_max=1, pulse activate -> up_m[0]=1 the next cycle; raise up_max at cycle 5 -> up_m[0]=0 the following cycle and door1 outputs stay 0 throughout.
- Obstruction reversal: door0 in MV_DN, assert obstruct for 1 cycle -> dn_m[0]=0 and up_m[0]=1 the next cycle, with the run counter restarted.
- Timeout: door1 in MV_UP, no limit for 16 cycles -> fault[1]=1 and up_m[1]=0; further activate pulses have no effect until rst=0.
- Stop and reverse: door0 in MV_UP, activate edge -> STOPPED with up_m=dn_m=0; next activate edge -> dn_m[0]=1; holding activate high for 10 cycles produces one event only.
- Sensor conflict and reset: up_max=dn_max=1 on door0 -> fault[0]=1; asserting rst mid-travel on door1 -> outputs 0 without a clock edge.
- Auto-close, with GARAGE_AUTOCLOSE_EN defined: door0 open and idle -> dn_m[0]=1 after 8 cycles; obstruct at cycle 4 -> count restarts.
